// File: rtl/uart_rx_frame.sv
// uart_rx_frame: frame-level UART receiver feeding the RX FIFO.
// Syncs rx, finds start bits, runs the baud generator, samples a frame, strobes newData.
// Ports:
//   clk, rst          system clock, sync active-high reset
//   rx                async serial line (idle high)
//   clk_uart          mid-bit baud square wave from the generator
//   uart_enable       runs the generator while a frame is in flight
//   data_size         0: 7 data bits, 1: 8 data bits
//   parity_en         parity bit present
//   parity_mode       11 odd, 10 even, 01 mark, 00 space
//   stop_bit_size     0: 1 stop bit, 1: 2 stop bits
//   data              received byte (bit 7 = 0 in 7-bit mode)
//   error_parity      parity mismatch for the frame in data
//   error_frame       a stop bit sampled 0
//   ready             high only while idle; gates config writes
//   newData           one-cycle strobe, data/errors valid
module uart_rx_frame #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       clk_uart,
   output logic       uart_enable,
   input  logic       data_size,
   input  logic       parity_en,
   input  logic [1:0] parity_mode,
   input  logic       stop_bit_size,
   output logic [7:0] data,
   output logic       error_parity,
   output logic       error_frame,
   output logic       ready,
   output logic       newData
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2,
      S_DONE
   } state_t;

   state_t state;

   logic [SYNC_STAGES-1:0] rx_sync;
   logic       rx_s;
   logic       rx_s_d;
   logic       cu_q;
   logic       cu_d;
   logic       fall;
   logic       smp;

   logic       cfg_8bit;
   logic       cfg_par;
   logic [1:0] cfg_pmode;
   logic       cfg_stop2;

   logic [7:0] shreg;
   logic [2:0] cnt;
   logic       perr;
   logic       ferr;
   logic       par_exp;
   logic       last_bit;

   assign rx_s = rx_sync[SYNC_STAGES-1];
   // rx_s_d only tracks rx_s, so a line held low never re-arms
   assign fall = rx_s_d & ~rx_s;
   assign smp  = cu_q & ~cu_d;
   assign last_bit = (cnt == (cfg_8bit ? 3'd7 : 3'd6));

   // shreg bit 7 stays 0 in 7-bit mode, so an 8-bit xor is correct
   always_comb begin
      par_exp = 1'b0;
      unique case (cfg_pmode)
         2'b11:   par_exp = ~^shreg;
         2'b10:   par_exp = ^shreg;
         2'b01:   par_exp = 1'b1;
         default: par_exp = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_sync <= '1;
         rx_s_d  <= 1'b1;
         cu_q    <= 1'b0;
         cu_d    <= 1'b0;
      end else begin
         rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx};
         rx_s_d  <= rx_s;
         cu_q    <= clk_uart;
         cu_d    <= cu_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         uart_enable  <= 1'b0;
         ready        <= 1'b1;
         newData      <= 1'b0;
         data         <= 8'h00;
         error_parity <= 1'b0;
         error_frame  <= 1'b0;
         cfg_8bit     <= 1'b0;
         cfg_par      <= 1'b0;
         cfg_pmode    <= 2'b00;
         cfg_stop2    <= 1'b0;
         shreg        <= 8'h00;
         cnt          <= 3'd0;
         perr         <= 1'b0;
         ferr         <= 1'b0;
      end else begin
         newData <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (fall) begin
                  state       <= S_START;
                  uart_enable <= 1'b1;
                  ready       <= 1'b0;
                  cfg_8bit    <= data_size;
                  cfg_par     <= parity_en;
                  cfg_pmode   <= parity_mode;
                  cfg_stop2   <= stop_bit_size;
                  shreg       <= 8'h00;
                  cnt         <= 3'd0;
                  perr        <= 1'b0;
                  ferr        <= 1'b0;
               end
            end
            S_START: begin
               if (smp) begin
                  if (rx_s) begin
                     state       <= S_IDLE;
                     uart_enable <= 1'b0;
                     ready       <= 1'b1;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (smp) begin
                  shreg[cnt] <= rx_s;
                  cnt        <= cnt + 3'd1;
                  if (last_bit) begin
                     state <= cfg_par ? S_PARITY : S_STOP1;
                  end
               end
            end
            S_PARITY: begin
               if (smp) begin
                  perr  <= (rx_s != par_exp);
                  state <= S_STOP1;
               end
            end
            S_STOP1: begin
               if (smp) begin
                  if (cfg_stop2) begin
                     ferr  <= ~rx_s;
                     state <= S_STOP2;
                  end else begin
                     state        <= S_DONE;
                     uart_enable  <= 1'b0;
                     newData      <= 1'b1;
                     data         <= shreg;
                     error_parity <= perr;
                     error_frame  <= ~rx_s;
                  end
               end
            end
            S_STOP2: begin
               if (smp) begin
                  state        <= S_DONE;
                  uart_enable  <= 1'b0;
                  newData      <= 1'b1;
                  data         <= shreg;
                  error_parity <= perr;
                  error_frame  <= ferr | ~rx_s;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               ready <= 1'b1;
            end
            default: begin
               state       <= S_IDLE;
               uart_enable <= 1'b0;
               ready       <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Frame-level UART receiver core that sits directly upstream of the receive FIFO in the UART receiver IP. It synchronises the `rx` line, detects start bits, enables the baud clock generator, samples data, parity and stop bits, and emits one parallel byte per frame with error flags. It produces a one-cycle `newData` strobe that pushes the byte into the FIFO. It also drives `ready`, which gates configuration writes.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on `rx` before use (≥2).
- `clk`  in  1  system clock (AXI clock)
- `rst`  in  1  synchronous, active-high reset
- `rx`  in  1  asynchronous serial line, idle high
- `clk_uart`  in  1  baud square wave from clock generator; low while `uart_enable`=0; first rising edge ½ bit after enable, then one per bit period (mid-bit)
- `uart_enable`  out  1  runs the clock generator while a frame is in progress
- `data_size`  in  1  0: 7 data bits, 1: 8 data bits
- `parity_en`  in  1  parity bit present
- `parity_mode`  in  2  11 odd, 10 even, 01 mark (1), 00 space (0)
- `stop_bit_size`  in  1  0: 1 stop bit, 1: 2 stop bits
- `data`  out  8  received byte, LSB first on line; bit 7 = 0 in 7-bit mode
- `error_parity`  out  1  parity mismatch for the frame in `data`
- `error_frame`  out  1  a stop bit sampled 0
- `ready`  out  1  high in IDLE only
- `newData`  out  1  one-cycle strobe: `data`/errors valid

## Operation
- `rx` passes through `SYNC_STAGES` flops, reset value 1, giving `rx_s`. `clk_uart` gets one registered copy. A sample event is a detected 0→1 transition of that copy.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
- IDLE: a 1→0 transition of `rx_s` moves to START and latches `data_size`, `parity_en`, `parity_mode`, `stop_bit_size` for the whole frame. A held-low line does not retrigger; a 1 must be seen first.
- START: first sample event. `rx_s`=0 means a valid start → DATA with bit counter = 0. `rx_s`=1 means a glitch → IDLE, with no `newData` and outputs unchanged.
- DATA: each sample event shifts `rx_s` in at bit position `counter`. After 7 or 8 bits, go to PARITY if `parity_en`, else STOP1.
- PARITY: one sample. Expected bit:
  - odd: ~^data
  - even: ^data
  - mark: 1
  - space: 0
  - A mismatch sets the parity error.
- STOP1: one sample; 0 sets the frame error. Go to STOP2 if 2 stop bits, else DONE. STOP2: same check, then DONE.
- DONE: for one cycle, update `data`, `error_parity`, `error_frame` and pulse `newData`. Then IDLE.
- Errors are per frame. Both clear at the start of each frame. With parity disabled, `error_parity`=0.
- `uart_enable` = 1 in START through STOP2, and 0 in IDLE and DONE.
- `ready` = 1 only in IDLE.
- `rst` mid-frame: return to IDLE next cycle and abandon the frame (no `newData`). Outputs go to their reset values.

## Timing
- Reset values:
  - `uart_enable`=0, `ready`=1, `newData`=0
  - `data`=8'h00, `error_parity`=0, `error_frame`=0
  - sync flops = 1
- Start detect: `uart_enable` rises `SYNC_STAGES`+1 cycles after the `rx` falling edge, and `ready` falls in the same cycle.
- Each sample uses `rx_s` in the cycle the `clk_uart` rising edge is detected: 1 cycle after the edge.
- `newData` is high exactly 1 cycle, the cycle after the last stop sample. `uart_enable`=0 and `ready`=1 the cycle after that.
- `data`/errors stay stable from `newData` until the next frame's DONE.
- Frame length in sample events: 1 + (7|8) + parity_en + (1|2), from 9 to 12.
- A consumer that is full does not stall this block. Overrun is the consumer's concern; `newData` still pulses.

## Test plan
- 8N1, send 0xA5 at 115200 with a clean line → one `newData`; `data`=0xA5, both errors 0; `ready` low for the frame, high after.
- 7E1 (`data_size`=0, `parity_en`=1, `parity_mode`=10), send 0x41 with parity bit 1 → `data`=0x41, `error_parity`=1. Repeat with parity bit 0 → `error_parity`=0.
- 8O2, send 0x00 with correct parity 1 but second stop bit forced 0 → `data`=0x00, `error_frame`=1, `error_parity`=0. Next frame 0xFF clean → both errors 0.
- `rx` low pulse shorter than ½ bit → START aborts; no `newData`; `uart_enable` drops; `ready` returns to 1. A following valid 0x3C frame is received correctly.
- Assert `rst` midway through the data bits of 0x5A → next cycle `uart_enable`=0, `ready`=1, `data`=0x00, no `newData`. The next full frame 0x5A is received correctly.
- Break (rx held low 3 frame times) → one frame with `data`=0x00 and `error_frame`=1. No further `newData` until `rx` goes high and a new falling edge occurs.
